// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle shared by the producers, the round-robin arbiter and the fifo.
// master drives requests/data/full; slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            i_req;
    logic [N_REQ*DATA_WIDTH-1:0] i_data;
    logic [N_REQ-1:0]            o_ack;
    logic [N_REQ-1:0]            o_grant;
    logic                        i_full;
    logic                        o_wr;
    logic [DATA_WIDTH-1:0]       o_w_data;
    logic [15:0]                 o_stall_cnt;

    modport master (
        output i_req, i_data, i_full,
        input  o_ack, o_grant, o_wr, o_w_data, o_stall_cnt
    );

    modport slave (
        input  i_req, i_data, i_full,
        output o_ack, o_grant, o_wr, o_w_data, o_stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ producers, bursts of up to MAX_BURST words.
// Optional stall statistics counter enabled by defining FIFO_WR_ARB_STATS_EN.
//
// state    | meaning
// ST_IDLE  | no owner; pick next requester after the last owner, no word accepted
// ST_BURST | owner holds the write port; accept words until MAX_BURST, drop of req, or reset
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_INIT  = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                state;
    logic [N_REQ-1:0]      grant;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      last;
    logic [PTR_W-1:0]      sel;
    logic [PTR_W-1:0]      scan_idx;
    logic [N_REQ-1:0]      ack;
    logic                  owner_req;
    logic [DATA_WIDTH-1:0] words [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign words[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from farthest to nearest so the requester right after the last owner wins.
    always_comb begin
        sel      = last;
        scan_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            scan_idx = PTR_W'((int'(last) + i) % N_REQ);
            if (bus.i_req[scan_idx]) begin
                sel = scan_idx;
            end
        end
    end

    assign owner_req = bus.i_req[last];

    // Reset blocks the accept so a word in flight stays with its producer.
    assign ack             = grant & bus.i_req & {N_REQ{~bus.i_full & ~i_reset}};
    assign bus.o_ack       = ack;
    assign bus.o_grant     = grant;
    assign bus.o_wr        = |ack;
    assign bus.o_w_data    = words[last];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            grant <= '0;
            count <= '0;
            last  <= PTR_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.i_req) begin
                        grant <= ONE << sel;
                        last  <= sel;
                        count <= '0;
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!owner_req) begin
                        grant <= '0;
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (!bus.i_full) begin
                        if (count == LAST_BEAT) begin
                            grant <= '0;
                            count <= '0;
                            state <= ST_IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt <= '0;
        end else if (state == ST_BURST && owner_req && bus.i_full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
`else
    assign bus.o_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle-level reference model compared every cycle, directed
// scenarios with literal expectations, and random traffic through a 4-deep fifo scoreboard.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef FIFO_WR_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic         full_dir = 1'b0;
    bit           use_fifo = 1'b0;
    bit           drain = 1'b0;
    int           fcnt = 0;
    logic [7:0]   fq[$];
    int           rd_seq[N];
    int           seq[N];
    int           sent[N];
    logic [N-1:0] req_v = '0;

    assign bus.i_full = use_fifo ? (fcnt >= 4) : full_dir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            if (bad >= 100) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task sample();
        @(negedge clk);
    endtask

    task drive();
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = 8'(k * 64 + (seq[k] % 64));
        bus.i_data = d;
        bus.i_req  = req_v;
    endtask

    task do_reset();
        rst      = 1'b1;
        req_v    = '0;
        full_dir = 1'b0;
        drive();
        step();
        rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    // Reference model: owner (-1 = none), words taken this grant, last owner, stall total.
    int m_owner = -1;
    int m_words = 0;
    int m_last  = N - 1;
    int m_stall = 0;

    always @(negedge clk) begin
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ack;
        logic [DW-1:0] e_data;
        int            pick;
        e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_ack   = (m_owner >= 0 && bus.i_req[m_owner] && !bus.i_full && !rst) ? e_grant : '0;
        chk("grant", 32'(bus.o_grant), 32'(e_grant));
        chk("ack", 32'(bus.o_ack), 32'(e_ack));
        chk("wr", 32'(bus.o_wr), 32'(e_ack != 0));
        chk("stall_cnt", 32'(bus.o_stall_cnt), STATS ? 32'(m_stall) : 32'd0);
        if (e_ack != 0) begin
            e_data = bus.i_data[m_owner*DW +: DW];
            chk("w_data", 32'(bus.o_w_data), 32'(e_data));
        end else begin
            chk("w_data_known", 32'($isunknown(bus.o_w_data)), 32'd0);
        end

        if (rst) begin
            m_owner = -1;
            m_words = 0;
            m_last  = N - 1;
            m_stall = 0;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && bus.i_req[(m_last + k) % N]) pick = (m_last + k) % N;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_last  = pick;
                m_words = 0;
            end
        end else if (!bus.i_req[m_owner]) begin
            m_owner = -1;
        end else if (bus.i_full) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_words++;
            if (m_words == MB) m_owner = -1;
        end
    end

    // Fifo of depth 4 with combinational full, fed by the arbiter.
    logic       wr_n;
    logic       pop_n;
    logic [7:0] wd_n;

    always @(negedge clk) begin
        wr_n  = bus.o_wr;
        wd_n  = bus.o_w_data;
        pop_n = use_fifo && fcnt > 0 && (drain || $urandom_range(0, 1) == 1);
    end

    always @(posedge clk) begin
        logic [7:0] w;
        int         src;
        if (use_fifo) begin
            if (pop_n) begin
                w   = fq.pop_front();
                src = int'(w[7:6]);
                chk("fifo_order", 32'(w[5:0]), 32'(rd_seq[src] % 64));
                rd_seq[src]++;
            end
            if (wr_n) fq.push_back(wd_n);
            fcnt <= fcnt + int'(wr_n) - int'(pop_n);
        end
    end

    int           n;
    int           wr_tot;
    int           cnt[N];
    int           ord[8];
    int           nord;
    logic [N-1:0] prev;
    logic [N-1:0] ack_s;
    int           exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int k = 0; k < N; k++) begin
            seq[k]    = 0;
            sent[k]   = 0;
            rd_seq[k] = 0;
        end
        drive();

        // req 0 and 2, fifo never full
        do_reset();
        req_v = 4'b0101;
        drive();
        sample();
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_wr", 32'(bus.o_wr), 32'd0);
        chk("rst_stall", 32'(bus.o_stall_cnt), 32'd0);
        step();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (i == 0) chk("t1_first_grant", 32'(bus.o_grant), 32'h1);
            if (bus.o_ack == 4'b0001) n++;
            step();
        end
        chk("t1_acks_req0", 32'(n), 32'd4);
        sample();
        chk("t1_bubble_grant", 32'(bus.o_grant), 32'd0);
        chk("t1_bubble_wr", 32'(bus.o_wr), 32'd0);
        step();
        sample();
        chk("t1_second_grant", 32'(bus.o_grant), 32'h4);
        step();

        // all four requesting continuously
        do_reset();
        req_v = 4'b1111;
        drive();
        nord   = 0;
        prev   = '0;
        wr_tot = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int s = 0; s < 22; s++) begin
            sample();
            if (bus.o_grant != 0 && bus.o_grant != prev && nord < 8) begin
                ord[nord] = oh_idx(bus.o_grant);
                nord++;
            end
            prev = bus.o_grant;
            if (s < 20) begin
                wr_tot += int'(bus.o_wr);
                for (int k = 0; k < N; k++) if (bus.o_ack[k]) cnt[k]++;
            end
            step();
        end
        chk("t2_num_grants", 32'(nord), 32'd5);
        for (int i = 0; i < 5; i++) chk("t2_grant_order", 32'(ord[i]), 32'(exp_ord[i]));
        for (int k = 0; k < N; k++) chk("t2_words_per_src", 32'(cnt[k]), 32'd4);
        chk("t2_words_in_20", 32'(wr_tot), 32'd16);

        // req1 drops after two words
        do_reset();
        req_v = 4'b0110;
        drive();
        step();
        sample();
        chk("t3_grant1", 32'(bus.o_grant), 32'h2);
        chk("t3_ack_w1", 32'(bus.o_ack), 32'h2);
        step();
        sample();
        chk("t3_ack_w2", 32'(bus.o_ack), 32'h2);
        step();
        req_v = 4'b0100;
        drive();
        sample();
        chk("t3_no_ack_after_drop", 32'(bus.o_ack), 32'd0);
        step();
        sample();
        chk("t3_released", 32'(bus.o_grant), 32'd0);
        step();
        req_v = 4'b0110;
        drive();
        sample();
        chk("t3_grant2", 32'(bus.o_grant), 32'h4);
        step();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int i = 0; i < 9; i++) begin
            sample();
            for (int k = 0; k < N; k++) if (bus.o_ack[k]) cnt[k]++;
            step();
        end
        chk("t3_req2_rest", 32'(cnt[2]), 32'd3);
        chk("t3_req1_fresh_burst", 32'(cnt[1]), 32'd4);

        // full for 5 cycles mid-burst
        do_reset();
        req_v = 4'b0001;
        drive();
        step();
        sample();
        step();
        full_dir = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (bus.o_wr !== 1'b0 || bus.o_grant !== 4'b0001) n++;
            step();
        end
        chk("t4_held_while_full", 32'(n), 32'd0);
        full_dir = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (i == 0) chk("t4_stall_cnt", 32'(bus.o_stall_cnt), STATS ? 32'd5 : 32'd0);
            if (bus.o_ack == 4'b0001) n++;
            step();
        end
        chk("t4_remaining_words", 32'(n), 32'd3);

        // reset in the middle of a burst
        do_reset();
        req_v = 4'b1010;
        drive();
        step();
        full_dir = 1'b1;
        sample();
        chk("t5_grant1", 32'(bus.o_grant), 32'h2);
        step();
        full_dir = 1'b0;
        rst      = 1'b1;
        sample();
        chk("t5_no_wr_in_reset", 32'(bus.o_wr), 32'd0);
        step();
        rst = 1'b0;
        sample();
        chk("t5_grant_cleared", 32'(bus.o_grant), 32'd0);
        chk("t5_wr_cleared", 32'(bus.o_wr), 32'd0);
        chk("t5_stall_cleared", 32'(bus.o_stall_cnt), 32'd0);
        step();
        sample();
        chk("t5_lowest_first", 32'(bus.o_grant), 32'h2);
        step();

        // random producers through the fifo
        do_reset();
        use_fifo = 1'b1;
        ack_s    = '0;
        for (int it = 0; it < 10000; it++) begin
            sample();
            ack_s = bus.o_ack;
            step();
            for (int k = 0; k < N; k++) begin
                if (ack_s[k]) begin
                    sent[k]++;
                    seq[k]++;
                    req_v[k] = ($urandom_range(0, 3) != 0);
                end else if (!req_v[k]) begin
                    req_v[k] = ($urandom_range(0, 3) == 0);
                end
            end
            drive();
        end
        req_v = '0;
        drive();
        drain = 1'b1;
        for (int i = 0; i < 60 && fcnt != 0; i++) step();
        chk("drain_empty", 32'(fcnt), 32'd0);
        for (int k = 0; k < N; k++) chk("src_word_count", 32'(rd_seq[k]), 32'(sent[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
